// File: rtl/tap_shift_buffer_if.sv
// tap_shift_buffer_if: sample-in / tap-out handshake bundle for tap_shift_buffer.
//   in_data/in_valid/in_ready       : upstream sample strobe (memory16bit q/done)
//   tap_data/tap_idx/tap_valid/
//   tap_ready/tap_last              : delay-line word stream toward the MAC
// Modports: master = the buffer itself, slave = the surrounding logic
// (sample source and MAC).
interface tap_shift_buffer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAPS  = 8
);
  localparam int unsigned IDX_W = $clog2(TAPS);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] tap_data;
  logic [IDX_W-1:0] tap_idx;
  logic             tap_valid;
  logic             tap_ready;
  logic             tap_last;

  modport master (
    input  in_data, in_valid, tap_ready,
    output in_ready, tap_data, tap_idx, tap_valid, tap_last
  );

  modport slave (
    output in_data, in_valid, tap_ready,
    input  in_ready, tap_data, tap_idx, tap_valid, tap_last
  );
endinterface

// File: rtl/tap_shift_buffer.sv
// tap_shift_buffer: TAPS-deep delay line. Each accepted sample is shifted in
// at tap 0, then every word (newest first) is streamed out once to the MAC.
// Ports:
//   clock, reset : single clock, synchronous active-high reset
//   bus          : tap_shift_buffer_if.master (sample in, tap stream out)
//   overrun      : only with TAP_SHIFT_OVERRUN_EN; sticky flag for samples
//                  that arrived while a stream was in progress
// Optional feature macro: TAP_SHIFT_OVERRUN_EN.
module tap_shift_buffer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAPS  = 8
) (
  input  logic                clock,
  input  logic                reset,
  tap_shift_buffer_if.master  bus
`ifdef TAP_SHIFT_OVERRUN_EN
  ,
  output logic                overrun
`endif
);
  localparam int unsigned     IDX_W    = $clog2(TAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] taps [TAPS];
  logic [IDX_W-1:0] idx, idx_nxt, idx_inc;
  logic             shift_en;

  logic             in_ready_q,  in_ready_nxt;
  logic             tap_valid_q, tap_valid_nxt;
  logic             tap_last_q,  tap_last_nxt;
  logic [WIDTH-1:0] tap_data_q,  tap_data_nxt;

  assign idx_inc = idx + IDX_W'(1);

  // State, index and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      in_ready_q  <= 1'b1;
      tap_valid_q <= 1'b0;
      tap_last_q  <= 1'b0;
      tap_data_q  <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      in_ready_q  <= in_ready_nxt;
      tap_valid_q <= tap_valid_nxt;
      tap_last_q  <= tap_last_nxt;
      tap_data_q  <= tap_data_nxt;
    end
  end

  // Delay line: shifts only when a sample is accepted
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < int'(TAPS); k++) taps[k] <= '0;
    end else if (shift_en) begin
      taps[0] <= bus.in_data;
      for (int k = 1; k < int'(TAPS); k++) taps[k] <= taps[k-1];
    end
  end

  // Next state and next output values; tap_data is preloaded with the word
  // that idx will point at after the edge, so outputs come straight from flops.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    shift_en      = 1'b0;
    in_ready_nxt  = in_ready_q;
    tap_valid_nxt = tap_valid_q;
    tap_last_nxt  = tap_last_q;
    tap_data_nxt  = tap_data_q;
    case (state)
      IDLE: begin
        in_ready_nxt  = 1'b1;
        tap_valid_nxt = 1'b0;
        tap_last_nxt  = 1'b0;
        tap_data_nxt  = '0;
        idx_nxt       = '0;
        if (bus.in_valid) begin
          shift_en      = 1'b1;
          state_nxt     = STREAM;
          in_ready_nxt  = 1'b0;
          tap_valid_nxt = 1'b1;
          tap_data_nxt  = bus.in_data;
        end
      end
      STREAM: begin
        if (bus.tap_ready) begin
          if (idx == LAST_IDX) begin
            state_nxt     = IDLE;
            idx_nxt       = '0;
            in_ready_nxt  = 1'b1;
            tap_valid_nxt = 1'b0;
            tap_last_nxt  = 1'b0;
            tap_data_nxt  = '0;
          end else begin
            idx_nxt      = idx_inc;
            tap_data_nxt = taps[idx_inc];
            tap_last_nxt = (idx_inc == LAST_IDX);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.tap_valid = tap_valid_q;
  assign bus.tap_last  = tap_last_q;
  assign bus.tap_data  = tap_data_q;
  assign bus.tap_idx   = idx;

`ifdef TAP_SHIFT_OVERRUN_EN
  // Sticky flag: a sample arrived while the delay line was busy streaming
  always_ff @(posedge clock) begin
    if (reset) overrun <= 1'b0;
    else if (state == STREAM && bus.in_valid) overrun <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_tap_shift_buffer.sv
// tb_tap_shift_buffer: randomized self-checking bench for tap_shift_buffer.
// The reference is a queue holding the last TAPS accepted samples, newest first.
module tb_tap_shift_buffer;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned TAPS  = 8;

  logic clock;
  logic reset;
`ifdef TAP_SHIFT_OVERRUN_EN
  logic overrun;
`endif

  tap_shift_buffer_if #(.WIDTH(WIDTH), .TAPS(TAPS)) bus ();

  tap_shift_buffer #(.WIDTH(WIDTH), .TAPS(TAPS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef TAP_SHIFT_OVERRUN_EN
    ,
    .overrun (overrun)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] hist[$];
  bit               ovr_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    foreach (hist[k]) hist[k] = '0;
    ovr_exp = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready), 1);
    check({tag, "_tap_valid"}, 32'(bus.tap_valid), 0);
    check({tag, "_tap_last"},  32'(bus.tap_last), 0);
    check({tag, "_tap_idx"},   32'(bus.tap_idx), 0);
    check({tag, "_tap_data"},  32'(bus.tap_data), 0);
`ifdef TAP_SHIFT_OVERRUN_EN
    check({tag, "_overrun"},   32'(overrun), 32'(ovr_exp));
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid  = 1'($urandom_range(0, 1));
    bus.in_data   = 16'($urandom);
    bus.tap_ready = 1'($urandom_range(0, 1));
    @(posedge clock); #1;
    reset = 1'b0;
    bus.in_valid  = 1'b0;
    bus.tap_ready = 1'b0;
    model_clear();
    check_idle("reset");
  endtask

  // mode: 0 = tap_ready always high, 1 = random, 2 = 3-cycle stall at idx 2
  // inject: 0 = none, 1 = random extra samples, 2 = FFFF on every stream cycle
  task automatic send_sample(input logic [WIDTH-1:0] d, input int mode,
                             input int abort_at, input int inject);
    int i;
    int cyc;
    int stall;
    bit rdy;
    check("pre_in_ready", 32'(bus.in_ready), 1);
    check("pre_tap_valid", 32'(bus.tap_valid), 0);
    bus.in_data   = d;
    bus.in_valid  = 1'b1;
    bus.tap_ready = 1'($urandom_range(0, 1));
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    hist.push_front(d);
    void'(hist.pop_back());
    i = 0; cyc = 0; stall = 0;
    while (i < int'(TAPS) && cyc < 200) begin
      check("tap_valid", 32'(bus.tap_valid), 1);
      check("tap_idx",   32'(bus.tap_idx), 32'(i));
      check("tap_data",  32'(bus.tap_data), 32'(hist[i]));
      check("tap_last",  32'(bus.tap_last), 32'(i == int'(TAPS) - 1));
      check("in_ready_busy", 32'(bus.in_ready), 0);
`ifdef TAP_SHIFT_OVERRUN_EN
      check("overrun", 32'(overrun), 32'(ovr_exp));
`endif
      if (i == abort_at) begin
        reset = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h7777;
        bus.tap_ready = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        bus.in_valid  = 1'b0;
        bus.tap_ready = 1'b0;
        model_clear();
        check_idle("abort");
        return;
      end
      case (mode)
        0: rdy = 1'b1;
        2: if (i == 2 && stall < 3) begin rdy = 1'b0; stall++; end else rdy = 1'b1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.tap_ready = rdy;
      if (inject == 2 || (inject == 1 && $urandom_range(0, 3) == 0)) begin
        bus.in_valid = 1'b1;
        bus.in_data  = (inject == 2) ? 16'hFFFF : 16'($urandom);
        ovr_exp = 1'b1;
      end
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      cyc++;
      if (rdy) i++;
    end
    check("stream_done", 32'(i), 32'(TAPS));
    if (mode == 0) check("stream_cycles", 32'(cyc), 32'(TAPS));
    if (mode == 2) check("stall_cycles", 32'(cyc), 32'(TAPS + 3));
    bus.tap_ready = 1'b0;
    check_idle("post");
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.tap_ready = 1'b0;
    ovr_exp = 1'b0;
    for (int k = 0; k < int'(TAPS); k++) hist.push_back('0);
    @(posedge clock); #1;
    do_reset();

    // Arbitrary activity, then reset: delay line must come back all zero
    send_sample(16'($urandom), 1, -1, 1);
    send_sample(16'($urandom), 1, -1, 0);
    do_reset();

    // Single sample into a cleared line
    send_sample(16'hABCD, 0, -1, 0);

    // Shift order over three back-to-back streams
    do_reset();
    send_sample(16'h1234, 0, -1, 0);
    send_sample(16'h5678, 0, -1, 0);
    send_sample(16'h9ABC, 0, -1, 0);

    // Back-pressure at idx 2
    send_sample(16'h4321, 2, -1, 0);

    // Samples during STREAM are dropped (and flagged when enabled)
    send_sample(16'h0F0F, 0, -1, 2);
    send_sample(16'h00AA, 1, -1, 0);

    // Reset mid-stream at idx 4, then a fresh sample
    send_sample(16'hBEEF, 1, 4, 1);
    send_sample(16'h0001, 0, -1, 0);

    // Random soak
    for (int n = 0; n < 20; n++)
      send_sample(16'($urandom), int'($urandom_range(0, 2)), -1, int'($urandom_range(0, 1)));

    do_reset();
    send_sample(16'($urandom), 0, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/tap_shift_buffer.md
TAP_SHIFT_BUFFER -- requirements
Module: tap_shift_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample and tap word width in bits.
REQ-002 SHALL have parameter TAPS, default 8, delay-line depth; legal range 2..64.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_data, input, WIDTH, new sample from the upstream memory16bit q output.
REQ-006 SHALL have port in_valid, input, 1, sample strobe, driven by the memory16bit done output.
REQ-007 SHALL have port in_ready, output, 1, high when a sample can be accepted.
REQ-008 SHALL have port tap_data, output, WIDTH, the delay-line word currently presented to the MAC.
REQ-009 SHALL have port tap_idx, output, clog2(TAPS), index of tap_data (0 = newest sample).
REQ-010 SHALL have port tap_valid, output, 1, tap_data/tap_idx are valid.
REQ-011 SHALL have port tap_ready, input, 1, MAC accepts the current tap.
REQ-012 SHALL have port tap_last, output, 1, high with tap_valid when tap_idx = TAPS-1.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and STREAM.
REQ-014 SHALL drive in_ready = 1 in IDLE and 0 in STREAM.
REQ-015 SHALL accept a sample on a rising edge with state IDLE and in_valid = 1: tap[0] <= in_data; tap[k] <= tap[k-1] for k = 1..TAPS-1; oldest word discarded; idx <= 0; state <= STREAM.
REQ-016 SHALL assert tap_valid in the cycle after acceptance, i.e. one-cycle latency from sample to first tap.
REQ-017 SHALL, in STREAM, drive tap_valid = 1, tap_data = tap[idx], tap_idx = idx.
REQ-018 SHALL advance idx by 1 on each edge with tap_valid & tap_ready; when tap_ready = 0, hold tap_data, tap_idx and tap_last stable.
REQ-019 SHALL return to IDLE and clear tap_valid on the edge where tap_last & tap_ready; idx SHALL NOT wrap past TAPS-1.
REQ-020 SHALL ignore in_valid in STREAM; delay-line contents stay unchanged until the stream completes.
REQ-021 SHALL drive tap_valid, tap_last, tap_idx and tap_data to 0 in IDLE.
REQ-022 SHALL allow a new sample to be accepted in the cycle immediately after return to IDLE, so back-to-back throughput is one sample per TAPS+1 cycles with tap_ready held high.

Reset
REQ-023 SHALL, with reset = 1 on a rising edge, clear every delay-line word to 0, set idx = 0 and state = IDLE, regardless of state.
REQ-024 SHALL, after reset, drive outputs in_ready = 1, tap_valid = 0, tap_last = 0, tap_idx = 0, tap_data = 0.
REQ-025 SHALL give reset priority over in_valid and tap_ready in the same cycle; an in-progress stream is abandoned with no further taps presented.

Configuration
REQ-026 SHALL support macro TAP_SHIFT_OVERRUN_EN.
REQ-027 SHALL, with TAP_SHIFT_OVERRUN_EN defined, add output port overrun, 1 bit, set on any edge with in_valid = 1 in STREAM, sticky until reset, reset value 0.
REQ-028 SHALL, without TAP_SHIFT_OVERRUN_EN, omit the overrun port and drop samples arriving in STREAM silently; all other behaviour identical.

Verification
REQ-029 Reset: assert reset 1 cycle after arbitrary activity -> in_ready = 1, tap_valid = 0, all taps 0 on the next stream.
REQ-030 Single sample, TAPS = 8: in_data = 16'hABCD, in_valid 1 cycle, tap_ready = 1 -> 8 taps next cycles: idx 0 = ABCD, idx 1..7 = 0000; tap_last only on idx 7; in_ready high again after 8 taps.
REQ-031 Shift order: samples 1234, 5678, 9ABC, each after its stream completes -> third stream shows idx 0 = 9ABC, idx 1 = 5678, idx 2 = 1234, rest 0000.
REQ-032 Back-pressure: tap_ready low for 3 cycles at idx 2 -> tap_idx = 2 and tap_data held for those 3 cycles, no tap skipped or repeated.
REQ-033 Overrun: in_valid = 1 with in_data = 16'hFFFF during STREAM -> sample not shifted in; with TAP_SHIFT_OVERRUN_EN, overrun = 1 until reset.
REQ-034 Reset mid-stream at idx 4 -> tap_valid = 0 next cycle, state IDLE, next accepted sample 16'h0001 streams as 0001 then seven 0000.
